// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with boot delay, halt mode, trap redirect and stall-deferred redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic        fetch_valid,
  output logic        misalign_fault,
  output logic [31:0] fault_addr
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam int CW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  state_t        state, state_nx;
  logic [CW-1:0] boot_cnt;
  logic          pending_valid, pending_nx, redirect, misalign;
  logic [31:0]   pending_target, pending_target_nx, target;
  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  always_comb begin
    state_nx          = state;
    pending_nx        = pending_valid;
    pending_target_nx = pending_target;
    misalign          = 1'b0;
    pc_next           = pc_cur;
    flush             = 1'b0;
    if (reset || state == BOOT) begin
      pc_next  = RESET_VECTOR;
      flush    = 1'b1;
      state_nx = (state == BOOT && boot_cnt == CW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
    end else if (trap_req) begin
      pc_next    = trap_vector;
      flush      = 1'b1;
      pending_nx = 1'b0;
      state_nx   = RUN;
    end else if (state == HALT) begin
      state_nx = (resume && !halt_req) ? RUN : HALT;
    end else if (redirect && target[1:0] != 2'b00) begin
      pc_next  = trap_vector;
      flush    = 1'b1;
      misalign = 1'b1;
    end else if (stall) begin
      if (redirect) begin
        pending_nx        = 1'b1;
        pending_target_nx = target;
      end
    end else if (pending_valid) begin
      pc_next    = pending_target;
      flush      = 1'b1;
      pending_nx = 1'b0;
    end else if (redirect) begin
      pc_next = target;
      flush   = 1'b1;
    end else if (halt_req) begin
      state_nx = HALT;
    end else begin
      pc_next = pc_cur + 32'd4;
    end
  end
  assign fetch_valid = state == RUN && !stall && !flush && !halt_req;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      boot_cnt       <= '0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      misalign_fault <= 1'b0;
      fault_addr     <= '0;
    end else begin
      state          <= state_nx;
      boot_cnt       <= state == BOOT ? boot_cnt + 1'b1 : '0;
      pending_valid  <= pending_nx;
      pending_target <= pending_target_nx;
      misalign_fault <= misalign;
      if (misalign) fault_addr <= target;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a behavioural next-PC model.
module tb_pc_sequencer;
  localparam int BOOT = 2;
  logic        clk = 0, reset, stall, branch_taken, jump, trap_req, halt_req, resume;
  logic [31:0] pc_cur, branch_target, jump_target, trap_vector;
  logic [31:0] pc_next, fault_addr;
  logic        flush, fetch_valid, misalign_fault;
  int checks = 0, fails = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0), .BOOT_CYCLES(BOOT)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap_req(trap_req),
    .trap_vector(trap_vector), .halt_req(halt_req), .resume(resume),
    .pc_next(pc_next), .flush(flush), .fetch_valid(fetch_valid),
    .misalign_fault(misalign_fault), .fault_addr(fault_addr));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; trap_req = 0; halt_req = 0; resume = 0;
    branch_target = 0; jump_target = 0; trap_vector = 32'h80;
  endtask

  // PC register behaviour: latch the sequencer's choice on each rising edge
  task automatic tick();
    logic [31:0] p;
    p = pc_next;
    @(posedge clk); #1;
    pc_cur = p;
  endtask

  task automatic test_reset();
    idle(); reset = 1; pc_cur = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pc_next !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b1) begin fails++; $display("FAIL reset_out pc=%h fv=%b fl=%b exp 0/0/1", pc_next, fetch_valid, flush); end
      tick();
    end
    reset = 0;
    for (int i = 0; i < BOOT; i++) begin
      @(negedge clk);
      checks++; if (pc_next !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b1) begin fails++; $display("FAIL boot_out cyc%0d pc=%h fv=%b fl=%b exp 0/0/1", i, pc_next, fetch_valid, flush); end
      checks++; if (misalign_fault !== 1'b0 || fault_addr !== 32'h0) begin fails++; $display("FAIL boot_fault mf=%b fa=%h exp 0/0", misalign_fault, fault_addr); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (pc_cur !== 32'(i * 4) || fetch_valid !== 1'b1) begin fails++; $display("FAIL run_seq pc_out=%h fv=%b exp %h/1", pc_cur, fetch_valid, 32'(i * 4)); end
      tick();
    end
  endtask

  task automatic test_stall();
    idle(); pc_cur = 32'h100; stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pc_next !== 32'h100 || flush !== 1'b0 || fetch_valid !== 1'b0) begin fails++; $display("FAIL stall_hold pc=%h fl=%b fv=%b exp 100/0/0", pc_next, flush, fetch_valid); end
      tick();
    end
    stall = 0;
    @(negedge clk);
    checks++; if (pc_next !== 32'h104 || fetch_valid !== 1'b1) begin fails++; $display("FAIL stall_release pc=%h fv=%b exp 104/1", pc_next, fetch_valid); end
    tick();
  endtask

  task automatic test_pending();
    idle(); pc_cur = 32'h100; stall = 1; branch_taken = 1; branch_target = 32'h200;
    @(negedge clk);
    checks++; if (pc_next !== 32'h100 || flush !== 1'b0) begin fails++; $display("FAIL pend_hold pc=%h fl=%b exp 100/0", pc_next, flush); end
    tick(); idle();
    @(negedge clk);
    checks++; if (pc_next !== 32'h200 || flush !== 1'b1) begin fails++; $display("FAIL pend_apply pc=%h fl=%b exp 200/1", pc_next, flush); end
    tick();
    @(negedge clk);
    checks++; if (pc_next !== 32'h204 || flush !== 1'b0) begin fails++; $display("FAIL pend_clear pc=%h fl=%b exp 204/0", pc_next, flush); end
    tick();
  endtask

  task automatic test_jump_priority();
    idle(); pc_cur = 32'h10; jump = 1; jump_target = 32'h300; branch_taken = 1; branch_target = 32'h400;
    @(negedge clk);
    checks++; if (pc_next !== 32'h300 || flush !== 1'b1 || fetch_valid !== 1'b0) begin fails++; $display("FAIL jump_prio pc=%h fl=%b fv=%b exp 300/1/0", pc_next, flush, fetch_valid); end
    tick(); idle();
  endtask

  task automatic test_misalign();
    idle(); pc_cur = 32'h20; jump = 1; jump_target = 32'h302;
    @(negedge clk);
    checks++; if (pc_next !== 32'h80 || flush !== 1'b1 || misalign_fault !== 1'b0) begin fails++; $display("FAIL mis_redirect pc=%h fl=%b mf=%b exp 80/1/0", pc_next, flush, misalign_fault); end
    tick(); idle();
    @(negedge clk);
    checks++; if (misalign_fault !== 1'b1 || fault_addr !== 32'h302) begin fails++; $display("FAIL mis_pulse mf=%b fa=%h exp 1/302", misalign_fault, fault_addr); end
    tick();
    @(negedge clk);
    checks++; if (misalign_fault !== 1'b0 || fault_addr !== 32'h302) begin fails++; $display("FAIL mis_end mf=%b fa=%h exp 0/302", misalign_fault, fault_addr); end
    branch_taken = 1; branch_target = 32'h201; stall = 1;
    @(negedge clk);
    checks++; if (pc_next !== 32'h80 || flush !== 1'b1) begin fails++; $display("FAIL mis_under_stall pc=%h fl=%b exp 80/1", pc_next, flush); end
    tick(); branch_target = 32'h203; stall = 0;
    @(negedge clk);
    checks++; if (misalign_fault !== 1'b1 || fault_addr !== 32'h201) begin fails++; $display("FAIL mis_b2b_1 mf=%b fa=%h exp 1/201", misalign_fault, fault_addr); end
    tick(); idle();
    @(negedge clk);
    checks++; if (misalign_fault !== 1'b1 || fault_addr !== 32'h203) begin fails++; $display("FAIL mis_b2b_2 mf=%b fa=%h exp 1/203", misalign_fault, fault_addr); end
    tick();
    @(negedge clk);
    checks++; if (misalign_fault !== 1'b0) begin fails++; $display("FAIL mis_b2b_end mf=%b exp 0", misalign_fault); end
    tick();
  endtask

  task automatic test_halt_trap();
    idle(); pc_cur = 32'h40; halt_req = 1;
    @(negedge clk);
    checks++; if (pc_next !== 32'h40 || fetch_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL halt_enter pc=%h fv=%b fl=%b exp 40/0/0", pc_next, fetch_valid, flush); end
    tick(); idle(); branch_taken = 1; branch_target = 32'h500;
    @(negedge clk);
    checks++; if (pc_next !== 32'h40 || fetch_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL halt_ignore_br pc=%h fv=%b fl=%b exp 40/0/0", pc_next, fetch_valid, flush); end
    tick(); idle(); halt_req = 1; resume = 1;
    tick(); idle();
    @(negedge clk);
    checks++; if (pc_next !== 32'h40 || fetch_valid !== 1'b0) begin fails++; $display("FAIL halt_resume_conflict pc=%h fv=%b exp 40/0", pc_next, fetch_valid); end
    trap_req = 1;
    @(negedge clk);
    checks++; if (pc_next !== 32'h80 || flush !== 1'b1) begin fails++; $display("FAIL halt_trap pc=%h fl=%b exp 80/1", pc_next, flush); end
    tick(); idle();
    @(negedge clk);
    checks++; if (pc_next !== 32'h84 || fetch_valid !== 1'b1) begin fails++; $display("FAIL trap_run pc=%h fv=%b exp 84/1", pc_next, fetch_valid); end
    halt_req = 1;
    tick(); idle(); resume = 1;
    @(negedge clk);
    checks++; if (pc_next !== 32'h84 || fetch_valid !== 1'b0) begin fails++; $display("FAIL resume_cycle pc=%h fv=%b exp 84/0", pc_next, fetch_valid); end
    tick(); idle();
    @(negedge clk);
    checks++; if (pc_next !== 32'h88 || fetch_valid !== 1'b1) begin fails++; $display("FAIL resumed pc=%h fv=%b exp 88/1", pc_next, fetch_valid); end
    tick();
  endtask

  task automatic test_wrap();
    idle(); pc_cur = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (pc_next !== 32'h0 || fetch_valid !== 1'b1) begin fails++; $display("FAIL wrap pc=%h fv=%b exp 0/1", pc_next, fetch_valid); end
    tick();
  endtask

  function automatic logic [31:0] rnd_target();
    return ($urandom & 32'hFFFF_FFFC) | ($urandom_range(0, 5) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
  endfunction

  // Model: mode 0 boot (counts down remaining cycles), 1 run, 2 halt
  task automatic test_random();
    int          mode = 0, left = 0, n_mode, n_left;
    logic        pend = 0, mf = 0, n_pend, n_mf, e_fl, e_fv, red;
    logic [31:0] ptgt = 0, fa = 0, n_ptgt, n_fa, e_pc, tgt;
    for (int i = 0; i < 2000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 99) == 0);
      stall = $urandom_range(0, 3) == 0;
      branch_taken = $urandom_range(0, 5) == 0;  branch_target = rnd_target();
      jump = $urandom_range(0, 7) == 0;          jump_target = rnd_target();
      trap_req = $urandom_range(0, 19) == 0;     trap_vector = $urandom & 32'hFFFF_FFFC;
      halt_req = $urandom_range(0, 15) == 0;     resume = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 3) == 0) pc_cur = $urandom & 32'hFFFF_FFFC;
      tgt = jump ? jump_target : branch_target;
      red = jump || branch_taken;
      n_mode = mode; n_left = left; n_pend = pend; n_ptgt = ptgt; n_mf = 0; n_fa = fa;
      e_pc = pc_cur; e_fl = 0;
      if (reset) begin
        e_pc = 0; e_fl = 1; n_mode = 0; n_left = BOOT; n_pend = 0; n_ptgt = 0; n_fa = 0;
      end else if (mode == 0) begin
        e_pc = 0; e_fl = 1; n_left = left - 1; if (n_left == 0) n_mode = 1;
      end else if (trap_req) begin
        e_pc = trap_vector; e_fl = 1; n_pend = 0; n_mode = 1;
      end else if (mode == 2) begin
        if (resume && !halt_req) n_mode = 1;
      end else if (red && tgt % 4 != 0) begin
        e_pc = trap_vector; e_fl = 1; n_mf = 1; n_fa = tgt;
      end else if (stall) begin
        if (red) begin n_pend = 1; n_ptgt = tgt; end
      end else if (pend) begin
        e_pc = ptgt; e_fl = 1; n_pend = 0;
      end else if (red) begin
        e_pc = tgt; e_fl = 1;
      end else if (halt_req) begin
        n_mode = 2;
      end else begin
        e_pc = pc_cur + 4;
      end
      e_fv = mode == 1 && !reset && !stall && !e_fl && !halt_req;
      @(negedge clk);
      checks++; if (pc_next !== e_pc || flush !== e_fl || fetch_valid !== e_fv) begin fails++; $display("FAIL rand_comb i=%0d pc=%h fl=%b fv=%b exp %h/%b/%b", i, pc_next, flush, fetch_valid, e_pc, e_fl, e_fv); end
      if (i > 0) begin
        checks++; if (misalign_fault !== mf || fault_addr !== fa) begin fails++; $display("FAIL rand_fault i=%0d mf=%b fa=%h exp %b/%h", i, misalign_fault, fault_addr, mf, fa); end
      end
      mode = n_mode; left = n_left; pend = n_pend; ptgt = n_ptgt; mf = n_mf; fa = n_fa;
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); pc_cur = 0;
    test_reset();
    test_stall();
    test_pending();
    test_jump_priority();
    test_misalign();
    test_halt_trap();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
